// File: rtl/clk_freq_monitor.sv
// Reference-clock-domain frequency check of a PLL output: counts monitored-clock
// rising edges over a fixed gate window and qualifies clk_ok on consecutive good windows.
module clk_freq_monitor #(
  parameter int GATE_CYCLES  = 50000,
  parameter int EXPECTED     = 4000,
  parameter int TOL          = 4,
  parameter int GOOD_WINDOWS = 4,
  parameter int CNT_W        = 16
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             mon_clk,
  input  logic             pll_locked,
  output logic [CNT_W-1:0] freq_count,
  output logic             freq_valid,
  output logic             in_range,
  output logic             clk_ok
);

  localparam int EW     = CNT_W + 1;
  localparam int GATE_W = $clog2(GATE_CYCLES);
  localparam int GOOD_W = $clog2(GOOD_WINDOWS + 1);

  localparam logic [GATE_W-1:0]  L_GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GOOD_W-1:0]  L_GOOD_MAX  = GOOD_W'(GOOD_WINDOWS);
  localparam logic signed [EW-1:0] L_EXP     = EW'(EXPECTED);
  localparam logic [EW-1:0]      L_TOL       = EW'(TOL);
  localparam logic [CNT_W-1:0]   L_SAT       = '1;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    DISCARD,
    MEASURE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic r_monS1, r_monS2, r_monS3;
  logic r_lockS1, r_lockS2;

  logic [GATE_W-1:0] r_gateCnt;
  logic [CNT_W-1:0]  r_edgeCnt;
  logic [GOOD_W-1:0] r_goodCnt;
  logic [CNT_W-1:0]  r_freqCount;
  logic              r_freqValid;
  logic              r_inRange;
  logic              r_clkOk;

  logic                 w_edge;
  logic                 w_gateLast;
  logic                 w_windowDone;
  logic [EW-1:0]        w_edgeSum;
  logic [CNT_W-1:0]     w_edgeSat;
  logic signed [EW-1:0] w_diff;
  logic [EW-1:0]        w_absDiff;
  logic                 w_inRange;
  logic [GOOD_W-1:0]    w_goodNext;

  always_ff @(posedge refclk) begin
    if (!rst) begin
      r_monS1  <= 1'b0;
      r_monS2  <= 1'b0;
      r_monS3  <= 1'b0;
      r_lockS1 <= 1'b0;
      r_lockS2 <= 1'b0;
    end else begin
      r_monS1  <= mon_clk;
      r_monS2  <= r_monS1;
      r_monS3  <= r_monS2;
      r_lockS1 <= pll_locked;
      r_lockS2 <= r_lockS1;
    end
  end

  assign w_edge       = r_monS2 & ~r_monS3;
  assign w_gateLast   = (r_gateCnt == L_GATE_LAST);
  assign w_windowDone = (r_state == MEASURE) && w_gateLast && r_lockS2;

  // Saturating sum includes the edge of the current cycle so the terminal cycle counts.
  assign w_edgeSum  = {1'b0, r_edgeCnt} + {{CNT_W{1'b0}}, w_edge};
  assign w_edgeSat  = w_edgeSum[CNT_W] ? L_SAT : w_edgeSum[CNT_W-1:0];
  assign w_diff     = $signed({1'b0, w_edgeSat}) - L_EXP;
  assign w_absDiff  = w_diff[CNT_W] ? -w_diff : w_diff;
  assign w_inRange  = (w_absDiff <= L_TOL);
  assign w_goodNext = (r_goodCnt == L_GOOD_MAX) ? r_goodCnt : r_goodCnt + GOOD_W'(1);

  always_ff @(posedge refclk) begin
    if (!rst) begin
      r_state <= WAIT_LOCK;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      WAIT_LOCK: if (r_lockS2) w_nextState = DISCARD;
      DISCARD:   if (w_gateLast) w_nextState = MEASURE;
      MEASURE:   w_nextState = MEASURE;
      default:   w_nextState = WAIT_LOCK;
    endcase
    if (!r_lockS2) begin
      w_nextState = WAIT_LOCK;
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst || r_state == WAIT_LOCK || !r_lockS2) begin
      r_gateCnt <= '0;
      r_edgeCnt <= '0;
    end else if (w_gateLast) begin
      r_gateCnt <= '0;
      r_edgeCnt <= '0;
    end else begin
      r_gateCnt <= r_gateCnt + GATE_W'(1);
      r_edgeCnt <= w_edgeSat;
    end
  end

  // Lock loss clears qualification at once; results only move on a completed window.
  always_ff @(posedge refclk) begin
    if (!rst) begin
      r_freqCount <= '0;
      r_freqValid <= 1'b0;
      r_inRange   <= 1'b0;
      r_clkOk     <= 1'b0;
      r_goodCnt   <= '0;
    end else begin
      r_freqValid <= w_windowDone;
      if (!r_lockS2) begin
        r_clkOk   <= 1'b0;
        r_goodCnt <= '0;
      end else if (w_windowDone) begin
        r_freqCount <= w_edgeSat;
        r_inRange   <= w_inRange;
        if (w_inRange) begin
          r_goodCnt <= w_goodNext;
          r_clkOk   <= (w_goodNext == L_GOOD_MAX);
        end else begin
          r_goodCnt <= '0;
          r_clkOk   <= 1'b0;
        end
      end
    end
  end

  assign freq_count = r_freqCount;
  assign freq_valid = r_freqValid;
  assign in_range   = r_inRange;
  assign clk_ok     = r_clkOk;

endmodule
